preg_mem_wb_skid: RTL and testbench

- Parametrised MEM/WB pipeline register for the cache-enabled core.
- Replaces the always-enabled stage latch with a valid/ready handshake and a 2-entry skid buffer, so a write-back-side stall does not cut throughput.
- Adds a synchronous flush that inserts bubbles, and gates RegWrite with valid.
- Exposes a forwarding port: the selected write-back result, with its destination register and valid flag, for the hazard unit.

---
 rtl/preg_mem_wb_skid.sv | 132 +++++++++++++
 tb/tb_preg_mem_wb_skid.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_mem_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake, optional 2-entry skid buffer, flush and forwarding port.
// Latency 1 cycle; with the skid, in_ready is registered from state and drops only once both entries are full.
module preg_mem_wb_skid #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int SKID_EN        = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     ALUResultM,
   input  logic [DATA_WIDTH-1:0]     DMRd,
   input  logic [DATA_WIDTH-1:0]     PCPlus4M,
   input  logic [REG_ADDR_WIDTH-1:0] RdM,
   input  logic                      RegWriteM,
   input  logic [1:0]                ResultSrcM,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     ALUResultW,
   output logic [DATA_WIDTH-1:0]     ReadDataW,
   output logic [DATA_WIDTH-1:0]     PCPlus4W,
   output logic [REG_ADDR_WIDTH-1:0] RdW,
   output logic                      RegWriteW,
   output logic [1:0]                ResultSrcW,
   output logic [DATA_WIDTH-1:0]     ResultW,
   output logic                      fwd_valid,
   output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
   output logic [DATA_WIDTH-1:0]     fwd_data
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]     alu;
      logic [DATA_WIDTH-1:0]     rdata;
      logic [DATA_WIDTH-1:0]     pc4;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      regwrite;
      logic [1:0]                src;
   } entry_t;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   rdy_q, rdy_d;
   entry_t in_ent;
   logic   accept, consume;

   assign in_ent = '{alu: ALUResultM, rdata: DMRd, pc4: PCPlus4M,
                     rd: RdM, regwrite: RegWriteM, src: ResultSrcM};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      accept  = in_valid && in_ready;
      consume = out_valid && out_ready;
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d = S_ONE;
               main_d  = in_ent;
            end
         end
         S_ONE: begin
            if (accept && consume) begin
               main_d = in_ent;
            end else if (accept) begin
               if (SKID_EN != 0) begin
                  state_d = S_TWO;
                  skid_d  = in_ent;
               end else begin
                  main_d = in_ent;
               end
            end else if (consume) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (consume) begin
               state_d = S_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      // Flush drops any same-cycle accept; a same-cycle consume has already been seen by WB.
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      rdy_d = (state_d != S_TWO);
   end

   always_comb begin
      out_valid = (state_q != S_EMPTY);
      if (SKID_EN != 0) in_ready = rdy_q;
      else              in_ready = rdy_q && (out_ready || !out_valid);
      ALUResultW = main_q.alu;
      ReadDataW  = main_q.rdata;
      PCPlus4W   = main_q.pc4;
      RdW        = main_q.rd;
      ResultSrcW = main_q.src;
      RegWriteW  = main_q.regwrite && out_valid;
      case (main_q.src)
         2'b01:   ResultW = main_q.rdata;
         2'b10:   ResultW = main_q.pc4;
         default: ResultW = main_q.alu;
      endcase
      fwd_valid = RegWriteW && (main_q.rd != '0);
      fwd_rd    = main_q.rd;
      fwd_data  = ResultW;
   end

endmodule

// File: tb/tb_preg_mem_wb_skid.sv
// Bench for preg_mem_wb_skid: skid and non-skid builds share stimulus, each checked against a queue model.
module tb_preg_mem_wb_skid;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, out_ready, flush, RegWriteM;
   logic [31:0] ALUResultM, DMRd, PCPlus4M;
   logic [4:0]  RdM;
   logic [1:0]  ResultSrcM;

   logic        s_in_ready, s_out_valid, s_RegWriteW, s_fwd_valid;
   logic [31:0] s_ALUResultW, s_ReadDataW, s_PCPlus4W, s_ResultW, s_fwd_data;
   logic [4:0]  s_RdW, s_fwd_rd;
   logic [1:0]  s_ResultSrcW;

   logic        n_in_ready, n_out_valid, n_RegWriteW, n_fwd_valid;
   logic [31:0] n_ALUResultW, n_ReadDataW, n_PCPlus4W, n_ResultW, n_fwd_data;
   logic [4:0]  n_RdW, n_fwd_rd;
   logic [1:0]  n_ResultSrcW;

   preg_mem_wb_skid #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID_EN(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .ALUResultM(ALUResultM), .DMRd(DMRd), .PCPlus4M(PCPlus4M), .RdM(RdM),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .flush(flush),
      .out_valid(s_out_valid), .out_ready(out_ready), .ALUResultW(s_ALUResultW),
      .ReadDataW(s_ReadDataW), .PCPlus4W(s_PCPlus4W), .RdW(s_RdW),
      .RegWriteW(s_RegWriteW), .ResultSrcW(s_ResultSrcW), .ResultW(s_ResultW),
      .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data));

   preg_mem_wb_skid #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID_EN(0)) dut_n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
      .ALUResultM(ALUResultM), .DMRd(DMRd), .PCPlus4M(PCPlus4M), .RdM(RdM),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .flush(flush),
      .out_valid(n_out_valid), .out_ready(out_ready), .ALUResultW(n_ALUResultW),
      .ReadDataW(n_ReadDataW), .PCPlus4W(n_PCPlus4W), .RdW(n_RdW),
      .RegWriteW(n_RegWriteW), .ResultSrcW(n_ResultSrcW), .ResultW(n_ResultW),
      .fwd_valid(n_fwd_valid), .fwd_rd(n_fwd_rd), .fwd_data(n_fwd_data));

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] rdd;
      logic [31:0] pc4;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  src;
   } ent_t;

   ent_t        q1[$];
   ent_t        q0[$];
   logic [31:0] log1[$];
   bit          started;
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic logic [31:0] exp_result(input ent_t e);
      case (e.src)
         2'b01:   return e.rdd;
         2'b10:   return e.pc4;
         default: return e.alu;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check_one(input string tag, input int n, input ent_t hd, input bit exp_ir,
                            input logic ov, input logic ir, input logic [31:0] alu,
                            input logic [31:0] rdd, input logic [31:0] pc4, input logic [4:0] rd,
                            input logic rw, input logic [1:0] src, input logic [31:0] res,
                            input logic fv, input logic [4:0] frd, input logic [31:0] fd);
      chk({tag, "out_valid"}, 32'(ov), 32'(n > 0));
      chk({tag, "in_ready"}, 32'(ir), 32'(exp_ir));
      chk({tag, "RegWriteW"}, 32'(rw), 32'(n > 0 && hd.rw));
      chk({tag, "fwd_valid"}, 32'(fv), 32'(n > 0 && hd.rw && hd.rd != '0));
      if (n > 0) begin
         chk({tag, "ALUResultW"}, alu, hd.alu);
         chk({tag, "ReadDataW"}, rdd, hd.rdd);
         chk({tag, "PCPlus4W"}, pc4, hd.pc4);
         chk({tag, "RdW"}, 32'(rd), 32'(hd.rd));
         chk({tag, "ResultSrcW"}, 32'(src), 32'(hd.src));
         chk({tag, "ResultW"}, res, exp_result(hd));
         chk({tag, "fwd_rd"}, 32'(frd), 32'(hd.rd));
         chk({tag, "fwd_data"}, fd, exp_result(hd));
      end
   endtask

   task automatic check_all();
      ent_t h1, h0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      h0 = (q0.size() > 0) ? q0[0] : '0;
      check_one("skid.", q1.size(), h1, started && q1.size() < 2,
                s_out_valid, s_in_ready, s_ALUResultW, s_ReadDataW, s_PCPlus4W, s_RdW,
                s_RegWriteW, s_ResultSrcW, s_ResultW, s_fwd_valid, s_fwd_rd, s_fwd_data);
      check_one("noskid.", q0.size(), h0, started && (out_ready || q0.size() == 0),
                n_out_valid, n_in_ready, n_ALUResultW, n_ReadDataW, n_PCPlus4W, n_RdW,
                n_RegWriteW, n_ResultSrcW, n_ResultW, n_fwd_valid, n_fwd_rd, n_fwd_data);
   endtask

   // One clock: compare against the model, then advance the model across the rising edge.
   task automatic cyc();
      bit   a1, c1, a0, c0;
      ent_t e;
      #1;
      check_all();
      e  = '{alu: ALUResultM, rdd: DMRd, pc4: PCPlus4M, rd: RdM, rw: RegWriteM, src: ResultSrcM};
      a1 = in_valid && started && q1.size() < 2;
      c1 = out_ready && q1.size() > 0;
      a0 = in_valid && started && (out_ready || q0.size() == 0);
      c0 = out_ready && q0.size() > 0;
      @(posedge clk);
      if (!rst) begin
         q1.delete(); q0.delete(); started = 1'b0;
      end else begin
         if (c1) log1.push_back(q1.pop_front().alu);
         if (c0) void'(q0.pop_front());
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (a1) q1.push_back(e);
            if (a0) q0.push_back(e);
         end
         started = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic drv(input bit iv, input logic [31:0] alu, input logic [31:0] dm,
                      input logic [4:0] rd, input bit rw, input logic [1:0] src,
                      input bit ordy, input bit fl);
      in_valid = iv; ALUResultM = alu; DMRd = dm; PCPlus4M = alu + 32'd4;
      RdM = rd; RegWriteM = rw; ResultSrcM = src; out_ready = ordy; flush = fl;
   endtask

   initial begin
      int L;
      started = 1'b0;
      rst = 1'b1;
      drv(1'b1, 32'h99, 32'h0, 5'd1, 1'b1, 2'b00, 1'b1, 1'b0);
      #2 rst = 1'b0;
      repeat (3) begin
         cyc();
         chk("reset.out_valid", 32'(s_out_valid), 32'd0);
         chk("reset.in_ready", 32'(s_in_ready), 32'd0);
         chk("reset.RegWriteW", 32'(s_RegWriteW), 32'd0);
         chk("reset.ALUResultW", s_ALUResultW, 32'd0);
      end
      rst = 1'b1;
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();
      #1 chk("release.in_ready", 32'(s_in_ready), 32'd1);

      for (int k = 0; k < 4; k++) begin
         drv(1'b1, 32'h10 + k, 32'h0, 5'd1, 1'b1, 2'b00, 1'b1, 1'b0);
         cyc();
         #1;
         chk("stream.skid.ResultW", s_ResultW, 32'h10 + k);
         chk("stream.noskid.ResultW", n_ResultW, 32'h10 + k);
      end
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();

      drv(1'b1, 32'hAAAA, 32'h0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      #1 chk("bp.first.ALUResultW", s_ALUResultW, 32'hAAAA);
      drv(1'b1, 32'hBBBB, 32'h0, 5'd2, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      #1;
      chk("bp.full.in_ready", 32'(s_in_ready), 32'd0);
      chk("bp.full.ALUResultW", s_ALUResultW, 32'hAAAA);
      chk("bp.noskid.ALUResultW", n_ALUResultW, 32'hAAAA);
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
      cyc();
      #1 chk("bp.hold.ALUResultW", s_ALUResultW, 32'hAAAA);
      L = log1.size();
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();
      #1 chk("bp.drain.ALUResultW", s_ALUResultW, 32'hBBBB);
      cyc();
      #1 chk("bp.drained.out_valid", 32'(s_out_valid), 32'd0);
      chk("bp.consumed.count", 32'(log1.size() - L), 32'd2);
      if (log1.size() == L + 2) begin
         chk("bp.consumed.first", log1[L], 32'hAAAA);
         chk("bp.consumed.second", log1[L+1], 32'hBBBB);
      end

      drv(1'b1, 32'h1111, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      drv(1'b1, 32'h2222, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      #1 chk("flush.pre.in_ready", 32'(s_in_ready), 32'd0);
      drv(1'b1, 32'hCCCC, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b1);
      cyc();
      #1;
      chk("flush.skid.out_valid", 32'(s_out_valid), 32'd0);
      chk("flush.noskid.out_valid", 32'(n_out_valid), 32'd0);
      chk("flush.in_ready", 32'(s_in_ready), 32'd1);
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();
      cyc();
      #1 chk("flush.C_absent.out_valid", 32'(s_out_valid), 32'd0);

      drv(1'b1, 32'h123, 32'hDEADBEEF, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0);
      cyc();
      #1;
      chk("fwd.valid", 32'(s_fwd_valid), 32'd1);
      chk("fwd.rd", 32'(s_fwd_rd), 32'd5);
      chk("fwd.data", s_fwd_data, 32'hDEADBEEF);
      drv(1'b1, 32'h123, 32'hDEADBEEF, 5'd0, 1'b1, 2'b01, 1'b1, 1'b0);
      cyc();
      #1;
      chk("fwd.x0.valid", 32'(s_fwd_valid), 32'd0);
      chk("fwd.x0.RegWriteW", 32'(s_RegWriteW), 32'd1);
      drv(1'b1, 32'h200, 32'h5, 5'd7, 1'b1, 2'b10, 1'b1, 1'b0);
      cyc();
      #1 chk("fwd.pc4.data", s_fwd_data, 32'h204);
      drv(1'b1, 32'h300, 32'h5, 5'd7, 1'b1, 2'b11, 1'b1, 1'b0);
      cyc();
      #1 chk("fwd.src11.ResultW", s_ResultW, 32'h300);
      drv(1'b1, 32'h400, 32'h5, 5'd7, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();
      #1 chk("fwd.norw.valid", 32'(s_fwd_valid), 32'd0);
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();

      drv(1'b1, 32'h5555, 32'h0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      #1;
      chk("noskid.stall.in_ready", 32'(n_in_ready), 32'd0);
      chk("noskid.stall.out_valid", 32'(n_out_valid), 32'd1);
      out_ready = 1'b1;
      #1 chk("noskid.comb.in_ready", 32'(n_in_ready), 32'd1);
      drv(1'b1, 32'h6666, 32'h0, 5'd3, 1'b1, 2'b00, 1'b1, 1'b0);
      cyc();
      #1;
      chk("noskid.replace.out_valid", 32'(n_out_valid), 32'd1);
      chk("noskid.replace.ALUResultW", n_ALUResultW, 32'h6666);
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();

      drv(1'b1, 32'h7777, 32'h0, 5'd4, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      drv(1'b1, 32'h8888, 32'h0, 5'd4, 1'b1, 2'b00, 1'b0, 1'b0);
      cyc();
      #1 chk("midrst.pre.in_ready", 32'(s_in_ready), 32'd0);
      rst = 1'b0;
      q1.delete(); q0.delete(); started = 1'b0;
      #1;
      chk("midrst.skid.out_valid", 32'(s_out_valid), 32'd0);
      chk("midrst.noskid.out_valid", 32'(n_out_valid), 32'd0);
      chk("midrst.in_ready", 32'(s_in_ready), 32'd0);
      chk("midrst.ALUResultW", s_ALUResultW, 32'd0);
      drv(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
      cyc();
      rst = 1'b1;
      cyc();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
